// File: rtl/gf8_mul_reduce_seq.sv
// gf8_mul_reduce_seq: sequential GF(2^8) multiplier back-end.
// Takes a, b and the upstream low carry-less product, builds the high
// product bits 14:8 one partial product per cycle, then reduces the
// 15-bit polynomial modulo {1, POLY} one bit per cycle.
module gf8_mul_reduce_seq #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] lo,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] y,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIMUL  = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Full degree-8 modulus with the implicit x^8 term made explicit.
    localparam logic [14:0] POLY_FULL = {6'd0, 1'b1, POLY};

    state_t      state_r, state_s;
    logic [14:0] p_r, p_s;
    logic [7:0]  ra_r, ra_s;
    logic [7:0]  rb_r, rb_s;
    logic [7:0]  y_r, y_s;
    logic [2:0]  i_r, i_s;
    logic [3:0]  k_r, k_s;
    logic        out_valid_r, out_valid_s;
    logic        accept_s;

    // High part of the partial product rb * x^i, aligned to bit 8.
    function automatic logic [6:0] himul_term(input logic [7:0] rb_v, input logic [2:0] i_v);
        logic [7:0] sh_v;
        sh_v = rb_v >> (4'd8 - {1'b0, i_v});
        return sh_v[6:0];
    endfunction

    // One reduction step at bit k: subtracting POLY_FULL * x^(k-8) also clears bit k.
    function automatic logic [14:0] reduce_step(input logic [14:0] p_v, input logic [3:0] k_v);
        logic [14:0] r_v;
        if (p_v[k_v]) begin
            r_v = p_v ^ (POLY_FULL << (k_v - 4'd8));
        end else begin
            r_v = p_v;
        end
        return r_v;
    endfunction

    assign in_ready  = (state_r == ST_IDLE) && rst_n;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign busy      = (state_r != ST_IDLE);

    // Next-state and datapath update for the IDLE/HIMUL/REDUCE/DONE sequence.
    always_comb begin
        state_s     = state_r;
        p_s         = p_r;
        ra_s        = ra_r;
        rb_s        = rb_r;
        y_s         = y_r;
        i_s         = i_r;
        k_s         = k_r;
        out_valid_s = out_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    ra_s    = a;
                    rb_s    = b;
                    p_s     = {7'd0, lo};
                    i_s     = 3'd1;
                    state_s = ST_HIMUL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HIMUL: begin
                if (ra_r[i_r]) begin
                    p_s[14:8] = p_r[14:8] ^ himul_term(rb_r, i_r);
                end else begin
                    p_s = p_r;
                end
                if (i_r == 3'd7) begin
                    k_s     = 4'd14;
                    state_s = ST_REDUCE;
                end else begin
                    i_s = i_r + 3'd1;
                end
            end
            ST_REDUCE: begin
                p_s = reduce_step(p_r, k_r);
                if (k_r == 4'd8) begin
                    y_s         = p_s[7:0];
                    out_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    k_s = k_r - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            p_r         <= 15'd0;
            ra_r        <= 8'd0;
            rb_r        <= 8'd0;
            y_r         <= 8'd0;
            i_r         <= 3'd0;
            k_r         <= 4'd0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            p_r         <= p_s;
            ra_r        <= ra_s;
            rb_r        <= rb_s;
            y_r         <= y_s;
            i_r         <= i_s;
            k_r         <= k_s;
            out_valid_r <= out_valid_s;
        end
    end

endmodule

// File: tb/tb_gf8_mul_reduce_seq.sv
// Self-checking bench for gf8_mul_reduce_seq: directed vectors, backpressure,
// mid-operation reset, back-to-back timing, random operands, POLY variant.
module tb_gf8_mul_reduce_seq;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] a, b, lo, y;
    logic       in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [7:0] a2, b2, lo2, y2;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    // Free-running edge counter for accept spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    gf8_mul_reduce_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .lo(lo), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    gf8_mul_reduce_seq #(.POLY(8'h1D)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .lo(lo2), .out_valid(out_valid2), .out_ready(out_ready2),
        .y(y2), .busy(busy2)
    );

    // Reference: shift-and-add field multiply with xtime reduction.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m, input logic [7:0] poly);
        logic [7:0] r = 8'h00;
        logic [7:0] t = x;
        for (int j = 0; j < 8; j++) begin
            if (m[j]) r = r ^ t;
            t = t[7] ? ((t << 1) ^ poly) : (t << 1);
        end
        return r;
    endfunction

    // Reference: low 8 bits of the carry-less product.
    function automatic logic [7:0] clmul_lo(input logic [7:0] x, input logic [7:0] m);
        logic [15:0] r = 16'h0000;
        for (int j = 0; j < 8; j++) if (m[j]) r = r ^ ({8'h00, x} << j);
        return r[7:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one cycle and let the edge accept them.
    task automatic accept(input logic [7:0] av, input logic [7:0] bv);
        a = av; b = bv; lo = clmul_lo(av, bv);
        in_valid = 1'b1;
        #1;
        check("accept_ready", {15'd0, in_ready}, 16'd1);
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); lo = 8'($urandom);
    endtask

    // Wait for out_valid, checking the 15-cycle latency and the result.
    task automatic wait_result(input string tag, input logic [7:0] exp);
        int  n  = 0;
        bit  ok = 1'b1;
        while (out_valid !== 1'b1 && n < 40) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            tick();
            n++;
        end
        check({tag, "_latency"}, 16'(n + 1), 16'd15);
        check({tag, "_y"}, {8'd0, y}, {8'd0, exp});
        check({tag, "_busy_noready"}, {15'd0, ok}, 16'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_idle", {14'd0, out_valid, busy}, 16'd0);
    endtask

    initial begin
        logic [7:0] ra, rb, held;
        int acc0, n, seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; lo = 8'h00;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = 8'h00; b2 = 8'h00; lo2 = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_state", {y, 5'd0, out_valid, busy, in_ready}, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {15'd0, in_ready}, 16'd1);

        // Directed vectors
        accept(8'h57, 8'h83); wait_result("v57x83", 8'hC1); release_result();
        accept(8'h57, 8'h13); wait_result("v57x13", 8'hFE); release_result();
        accept(8'h80, 8'h80); wait_result("v80x80", 8'h9A); release_result();
        accept(8'h80, 8'h02); wait_result("v80x02", 8'h1B); release_result();
        accept(8'h01, 8'hFF); wait_result("v01xFF", 8'hFF); release_result();
        accept(8'h00, 8'hA5); wait_result("v00xA5", 8'h00); release_result();

        // Backpressure with in_valid toggling during DONE
        accept(8'h57, 8'h83); wait_result("bp", 8'hC1);
        held = y;
        for (int j = 0; j < 5; j++) begin
            in_valid = j[0]; a = 8'($urandom); b = 8'($urandom); lo = 8'($urandom);
            tick();
            check("bp_hold", {y, 6'd0, out_valid, in_ready}, {held, 8'h02});
        end
        in_valid = 1'b0;
        release_result();

        // Reset during REDUCE aborts the operation
        accept(8'h57, 8'h83);
        for (int j = 0; j < 8; j++) tick();
        check("mid_busy", {15'd0, busy}, 16'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst", {y, 6'd0, out_valid, busy}, 16'h0000);
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        check("mid_no_result", 16'(seen), 16'd0);
        accept(8'h57, 8'h83); wait_result("post_rst", 8'hC1); release_result();

        // Back-to-back with out_ready and in_valid held high
        out_ready = 1'b1; in_valid = 1'b1;
        a = 8'h57; b = 8'h83; lo = clmul_lo(8'h57, 8'h83);
        #1;
        check("b2b_ready0", {15'd0, in_ready}, 16'd1);
        tick();
        acc0 = cyc;
        a = 8'h57; b = 8'h13; lo = clmul_lo(8'h57, 8'h13);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        check("b2b_y0", {8'd0, y}, 16'h00C1);
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
        tick();
        check("b2b_spacing", 16'(cyc - acc0), 16'd16);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        check("b2b_y1", {8'd0, y}, 16'h00FE);
        tick();
        out_ready = 1'b0;
        check("b2b_idle", {15'd0, busy}, 16'd0);

        // Random operands against the reference model
        for (int t = 0; t < 20; t++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            accept(ra, rb);
            wait_result("rand", gf_mul(ra, rb, 8'h1B));
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
            release_result();
        end

        // POLY = 8'h1D variant
        a2 = 8'h80; b2 = 8'h02; lo2 = clmul_lo(8'h80, 8'h02); in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        n = 0;
        while (out_valid2 !== 1'b1 && n < 40) begin tick(); n++; end
        check("poly1d_latency", 16'(n + 1), 16'd15);
        check("poly1d_y", {8'd0, y2}, {8'd0, gf_mul(8'h80, 8'h02, 8'h1D)});
        check("poly1d_const", {8'd0, y2}, 16'h001D);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        check("poly1d_idle", {15'd0, out_valid2}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
